// File: rtl/wb_arbiter.sv
// Round-robin write-back arbiter: NUM_FU producers into one register-file port.
// Optional one-entry output register enabled by defining WB_ARB_OUT_REG_EN.
module wb_arbiter #(
    parameter int NUM_FU      = 4,
    parameter int NUM_REG     = 8,
    parameter int REG_BIT     = 16,
    parameter int INST_ID_BIT = 8,
    parameter int REG_ID_BIT  = $clog2(NUM_REG),
    parameter int FU_ID_BIT   = $clog2(NUM_FU)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_FU-1:0]             fu_wb_vld,
    output logic [NUM_FU-1:0]             fu_wb_rdy,
    input  logic [NUM_FU*INST_ID_BIT-1:0] fu_wb_id,
    input  logic [NUM_FU*REG_ID_BIT-1:0]  fu_wb_reg_id,
    input  logic [NUM_FU*REG_BIT-1:0]     fu_wb_addr,
    input  logic [NUM_FU*REG_BIT-1:0]     fu_wb_val,
    output logic                          rf_wr_vld,
    input  logic                          rf_wr_rdy,
    output logic [INST_ID_BIT-1:0]        rf_wr_id,
    output logic [REG_ID_BIT-1:0]         rf_wr_reg_id,
    output logic [REG_BIT-1:0]            rf_wr_addr,
    output logic [REG_BIT-1:0]            rf_wr_val,
    output logic [FU_ID_BIT-1:0]          rf_wr_fu,
    output logic                          idle
);

    logic [FU_ID_BIT-1:0]   ptr;
    logic [FU_ID_BIT-1:0]   ptr_nxt;
    logic [FU_ID_BIT-1:0]   lock_idx;
    logic                   lock_vld;
    logic [FU_ID_BIT-1:0]   rr_idx;
    logic                   rr_found;
    logic [FU_ID_BIT-1:0]   cand_idx;
    int                     cand;
    logic [FU_ID_BIT-1:0]   g;
    logic                   grant_vld;
    logic                   accept;
    logic                   hs_fu;
    logic [INST_ID_BIT-1:0] sel_id;
    logic [REG_ID_BIT-1:0]  sel_reg_id;
    logic [REG_BIT-1:0]     sel_addr;
    logic [REG_BIT-1:0]     sel_val;

    // Cyclic search for the first valid FU starting at ptr.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        cand     = 0;
        cand_idx = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            cand     = (int'(ptr) + k) % NUM_FU;
            cand_idx = FU_ID_BIT'(cand);
            if (!rr_found && fu_wb_vld[cand_idx]) begin
                rr_found = 1'b1;
                rr_idx   = cand_idx;
            end
        end
    end

    // A held lock overrides the search; a withdrawn lock grants nothing.
    always_comb begin
        grant_vld = 1'b0;
        g         = rr_idx;
        if (!rst_n) begin
            grant_vld = 1'b0;
        end else if (lock_vld) begin
            g         = lock_idx;
            grant_vld = fu_wb_vld[lock_idx];
        end else begin
            grant_vld = rr_found;
        end
    end

    assign hs_fu   = grant_vld && accept;
    assign ptr_nxt = (g == FU_ID_BIT'(NUM_FU - 1)) ? '0 : g + 1'b1;

    assign sel_id     = fu_wb_id[int'(g)*INST_ID_BIT +: INST_ID_BIT];
    assign sel_reg_id = fu_wb_reg_id[int'(g)*REG_ID_BIT +: REG_ID_BIT];
    assign sel_addr   = fu_wb_addr[int'(g)*REG_BIT +: REG_BIT];
    assign sel_val    = fu_wb_val[int'(g)*REG_BIT +: REG_BIT];

    // Only the granted FU may see ready, and only when it is taken.
    always_comb begin
        fu_wb_rdy = '0;
        if (hs_fu) begin
            fu_wb_rdy[g] = 1'b1;
        end
    end

    // Pointer advances past the winner; lock holds a stalled grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr      <= '0;
            lock_vld <= 1'b0;
            lock_idx <= '0;
        end else if (hs_fu) begin
            ptr      <= ptr_nxt;
            lock_vld <= 1'b0;
        end else if (grant_vld) begin
            lock_vld <= 1'b1;
            lock_idx <= g;
        end else begin
            lock_vld <= 1'b0;
        end
    end

`ifdef WB_ARB_OUT_REG_EN
    logic                   ent_vld;
    logic [INST_ID_BIT-1:0] ent_id;
    logic [REG_ID_BIT-1:0]  ent_reg_id;
    logic [REG_BIT-1:0]     ent_addr;
    logic [REG_BIT-1:0]     ent_val;
    logic [FU_ID_BIT-1:0]   ent_fu;

    assign accept = !ent_vld || rf_wr_rdy;

    // Output entry refills in the same cycle it drains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent_vld    <= 1'b0;
            ent_id     <= '0;
            ent_reg_id <= '0;
            ent_addr   <= '0;
            ent_val    <= '0;
            ent_fu     <= '0;
        end else if (hs_fu) begin
            ent_vld    <= 1'b1;
            ent_id     <= sel_id;
            ent_reg_id <= sel_reg_id;
            ent_addr   <= sel_addr;
            ent_val    <= sel_val;
            ent_fu     <= g;
        end else if (rf_wr_rdy) begin
            ent_vld    <= 1'b0;
        end
    end

    assign rf_wr_vld    = ent_vld;
    assign rf_wr_id     = ent_vld ? ent_id : '0;
    assign rf_wr_reg_id = ent_vld ? ent_reg_id : '0;
    assign rf_wr_addr   = ent_vld ? ent_addr : '0;
    assign rf_wr_val    = ent_vld ? ent_val : '0;
    assign rf_wr_fu     = ent_vld ? ent_fu : '0;
    assign idle         = !rst_n ||
                          (!(|fu_wb_vld) && !lock_vld && !ent_vld);
`else
    assign accept = rf_wr_rdy;

    assign rf_wr_vld    = grant_vld;
    assign rf_wr_id     = grant_vld ? sel_id : '0;
    assign rf_wr_reg_id = grant_vld ? sel_reg_id : '0;
    assign rf_wr_addr   = grant_vld ? sel_addr : '0;
    assign rf_wr_val    = grant_vld ? sel_val : '0;
    assign rf_wr_fu     = grant_vld ? g : '0;
    assign idle         = !rst_n || (!(|fu_wb_vld) && !lock_vld);
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter, default build or WB_ARB_OUT_REG_EN.
// Expected write-backs are queued as FUs are loaded and popped at rf_wr.
module tb_wb_arbiter;

    localparam int NF = 4;
    localparam int IB = 8;
    localparam int RB = 3;
    localparam int DB = 16;
    localparam int FB = 2;
`ifdef WB_ARB_OUT_REG_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    typedef struct {
        logic [FB-1:0] fu;
        logic [IB-1:0] id;
        logic [RB-1:0] rg;
        logic [DB-1:0] addr;
        logic [DB-1:0] val;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [NF-1:0]    fu_wb_vld = '0;
    logic [NF-1:0]    fu_wb_rdy;
    logic [NF*IB-1:0] fu_wb_id = '0;
    logic [NF*RB-1:0] fu_wb_reg_id = '0;
    logic [NF*DB-1:0] fu_wb_addr = '0;
    logic [NF*DB-1:0] fu_wb_val = '0;
    logic             rf_wr_vld;
    logic             rf_wr_rdy = 1'b0;
    logic [IB-1:0]    rf_wr_id;
    logic [RB-1:0]    rf_wr_reg_id;
    logic [DB-1:0]    rf_wr_addr;
    logic [DB-1:0]    rf_wr_val;
    logic [FB-1:0]    rf_wr_fu;
    logic             idle;

    exp_t q[$];
    int   n_chk = 0;
    int   n_fail = 0;

    wb_arbiter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .fu_wb_vld    (fu_wb_vld),
        .fu_wb_rdy    (fu_wb_rdy),
        .fu_wb_id     (fu_wb_id),
        .fu_wb_reg_id (fu_wb_reg_id),
        .fu_wb_addr   (fu_wb_addr),
        .fu_wb_val    (fu_wb_val),
        .rf_wr_vld    (rf_wr_vld),
        .rf_wr_rdy    (rf_wr_rdy),
        .rf_wr_id     (rf_wr_id),
        .rf_wr_reg_id (rf_wr_reg_id),
        .rf_wr_addr   (rf_wr_addr),
        .rf_wr_val    (rf_wr_val),
        .rf_wr_fu     (rf_wr_fu),
        .idle         (idle)
    );

    always #5 clk = ~clk;

    // Drive FU i with a payload; optionally expect it at rf_wr.
    task automatic load(input int i, input logic [IB-1:0] id,
                        input logic [RB-1:0] rg,
                        input logic [DB-1:0] addr,
                        input logic [DB-1:0] val, input bit expect_wr);
        exp_t e;
        fu_wb_id[i*IB +: IB]     = id;
        fu_wb_reg_id[i*RB +: RB] = rg;
        fu_wb_addr[i*DB +: DB]   = addr;
        fu_wb_val[i*DB +: DB]    = val;
        fu_wb_vld[i]             = 1'b1;
        if (expect_wr) begin
            e.fu = FB'(i);
            e.id = id;
            e.rg = rg;
            e.addr = addr;
            e.val = val;
            q.push_back(e);
        end
    endtask

    // Called at negedge: scoreboard the rf_wr port, then clock the
    // FUs, which withdraw once their write-back was accepted.
    task automatic adv();
        exp_t e;
        logic [NF-1:0] hs;
        if (rf_wr_vld && rf_wr_rdy) begin
            n_chk++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_wr: got fu=%0d id=%h none expected",
                         rf_wr_fu, rf_wr_id);
            end else begin
                e = q.pop_front();
                if ({rf_wr_fu, rf_wr_id, rf_wr_reg_id, rf_wr_addr,
                     rf_wr_val} !== {e.fu, e.id, e.rg, e.addr, e.val}) begin
                    n_fail++;
                    $display("FAIL wr_data: got fu=%0d id=%h reg=%0d addr=%h val=%h expected fu=%0d id=%h reg=%0d addr=%h val=%h",
                             rf_wr_fu, rf_wr_id, rf_wr_reg_id, rf_wr_addr,
                             rf_wr_val, e.fu, e.id, e.rg, e.addr, e.val);
                end
            end
        end else if (!rf_wr_vld) begin
            n_chk++;
            if ({rf_wr_fu, rf_wr_id, rf_wr_reg_id, rf_wr_addr,
                 rf_wr_val} !== '0) begin
                n_fail++;
                $display("FAIL idle_payload: got id=%h val=%h expected 0",
                         rf_wr_id, rf_wr_val);
            end
        end
        hs = fu_wb_vld & fu_wb_rdy;
        @(posedge clk);
        #1;
        fu_wb_vld = fu_wb_vld & ~hs;
    endtask

    task automatic step();
        @(negedge clk);
        adv();
    endtask

    // Run until every expected write-back appeared, bounded.
    task automatic drain(input string tag);
        for (int n = 0; n < 20 && q.size() > 0; n++) begin
            step();
        end
        n_chk++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain: got %0d pending expected 0",
                     tag, q.size());
            q.delete();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rf_wr_rdy = 1'b1;
        load(0, 8'h01, 3'd1, 16'h1, 16'h1, 1'b0);
        load(2, 8'h02, 3'd2, 16'h2, 16'h2, 1'b0);
        repeat (2) @(negedge clk);
        n_chk++;
        if ({rf_wr_vld, fu_wb_rdy, idle} !== {1'b0, 4'b0000, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_out: got vld=%b rdy=%b idle=%b expected 0 0000 1",
                     rf_wr_vld, fu_wb_rdy, idle);
        end
        @(posedge clk);
        #1;
        fu_wb_vld = '0;
        rst_n = 1'b1;
        @(negedge clk);
        n_chk++;
        if ({rf_wr_vld, idle} !== 2'b01) begin
            n_fail++;
            $display("FAIL reset_release: got vld=%b idle=%b expected 0 1",
                     rf_wr_vld, idle);
        end
        adv();
    endtask

    task automatic test_round_robin();
        rf_wr_rdy = 1'b1;
        for (int i = 0; i < NF; i++) begin
            load(i, 8'h10 + 8'(i), 3'(i + 1), 16'h0100 + 16'(i),
                 16'hA000 + 16'(i), 1'b1);
        end
        for (int k = 0; k < NF; k++) begin
            @(negedge clk);
            n_chk++;
            if (fu_wb_rdy !== 4'(1 << k)) begin
                n_fail++;
                $display("FAIL rr_grant%0d: got rdy=%b expected %b",
                         k, fu_wb_rdy, 4'(1 << k));
            end
            adv();
        end
        drain("rr");
        load(0, 8'h20, 3'd6, 16'h0200, 16'h5A5A, 1'b1);
        load(3, 8'h23, 3'd7, 16'h0203, 16'hA5A5, 1'b1);
        @(negedge clk);
        n_chk++;
        if (fu_wb_rdy !== 4'b0001) begin
            n_fail++;
            $display("FAIL rr_ptr_wrap: got rdy=%b expected 0001",
                     fu_wb_rdy);
        end
        adv();
        drain("rr_wrap");
        @(negedge clk);
        n_chk++;
        if (idle !== 1'b1) begin
            n_fail++;
            $display("FAIL rr_idle: got %b expected 1", idle);
        end
        adv();
    endtask

    task automatic test_lock();
        rf_wr_rdy = 1'b0;
        load(2, 8'h17, 3'd2, 16'h0302, 16'h2222, 1'b1);
        @(negedge clk);
        n_chk++;
        if (fu_wb_rdy !== (LAT == 1 ? 4'b0100 : 4'b0000)) begin
            n_fail++;
            $display("FAIL lock_c0_rdy: got %b expected %b", fu_wb_rdy,
                     LAT == 1 ? 4'b0100 : 4'b0000);
        end
        adv();
        for (int c = 1; c < 3; c++) begin
            if (c == 2) begin
                load(0, 8'h30, 3'd3, 16'h0300, 16'h3333, 1'b1);
            end
            @(negedge clk);
            n_chk++;
            if ({fu_wb_rdy, rf_wr_vld, rf_wr_fu, rf_wr_id} !==
                {4'b0000, 1'b1, 2'd2, 8'h17}) begin
                n_fail++;
                $display("FAIL lock_hold%0d: got rdy=%b vld=%b fu=%0d id=%h expected 0000 1 2 17",
                         c, fu_wb_rdy, rf_wr_vld, rf_wr_fu, rf_wr_id);
            end
            adv();
        end
        rf_wr_rdy = 1'b1;
        @(negedge clk);
        n_chk++;
        if ({fu_wb_rdy, rf_wr_fu} !==
            {(LAT == 1 ? 4'b0001 : 4'b0100), 2'd2}) begin
            n_fail++;
            $display("FAIL lock_release: got rdy=%b fu=%0d expected %b 2",
                     fu_wb_rdy, rf_wr_fu,
                     LAT == 1 ? 4'b0001 : 4'b0100);
        end
        adv();
        drain("lock");
    endtask

    task automatic test_single();
        rf_wr_rdy = 1'b1;
        load(3, 8'h33, 3'd5, 16'h0403, 16'h1234, 1'b1);
        drain("single");
        @(negedge clk);
        n_chk++;
        if (idle !== 1'b1) begin
            n_fail++;
            $display("FAIL single_idle: got %b expected 1", idle);
        end
        adv();
        load(1, 8'h41, 3'd1, 16'h0501, 16'h1111, 1'b1);
        load(0, 8'h40, 3'd0, 16'h0500, 16'h0000, 1'b0);
        q.push_front('{fu: 2'd0, id: 8'h40, rg: 3'd0,
                       addr: 16'h0500, val: 16'h0000});
        @(negedge clk);
        n_chk++;
        if (fu_wb_rdy !== 4'b0001) begin
            n_fail++;
            $display("FAIL single_ptr: got rdy=%b expected 0001",
                     fu_wb_rdy);
        end
        adv();
        drain("single_ptr");
    endtask

    task automatic test_back_to_back();
        rf_wr_rdy = 1'b1;
        load(1, 8'h51, 3'd1, 16'h0601, 16'hBEEF, 1'b1);
        @(negedge clk);
        n_chk++;
        if ({fu_wb_rdy, rf_wr_vld, rf_wr_val} !==
            {4'b0010, (LAT == 0), (LAT == 0 ? 16'hBEEF : 16'h0)}) begin
            n_fail++;
            $display("FAIL b2b_t0: got rdy=%b vld=%b val=%h",
                     fu_wb_rdy, rf_wr_vld, rf_wr_val);
        end
        adv();
        load(2, 8'h52, 3'd2, 16'h0602, 16'hCAFE, 1'b1);
        @(negedge clk);
        n_chk++;
        if ({fu_wb_rdy, rf_wr_vld, rf_wr_fu} !==
            {4'b0100, 1'b1, (LAT == 1 ? 2'd1 : 2'd2)}) begin
            n_fail++;
            $display("FAIL b2b_t1: got rdy=%b vld=%b fu=%0d",
                     fu_wb_rdy, rf_wr_vld, rf_wr_fu);
        end
        adv();
        @(negedge clk);
        n_chk++;
        if (rf_wr_vld !== (LAT == 1)) begin
            n_fail++;
            $display("FAIL b2b_t2: got vld=%b expected %b",
                     rf_wr_vld, LAT == 1);
        end
        adv();
        drain("b2b");
    endtask

    task automatic test_reset_locked();
        rf_wr_rdy = 1'b0;
        load(1, 8'h55, 3'd4, 16'h0701, 16'hDEAD, 1'b0);
        step();
        @(negedge clk);
        n_chk++;
        if ({rf_wr_vld, rf_wr_fu, rf_wr_id} !== {1'b1, 2'd1, 8'h55}) begin
            n_fail++;
            $display("FAIL rstlk_held: got vld=%b fu=%0d id=%h expected 1 1 55",
                     rf_wr_vld, rf_wr_fu, rf_wr_id);
        end
        adv();
        rst_n = 1'b0;
        @(negedge clk);
        n_chk++;
        if ({rf_wr_vld, fu_wb_rdy, idle} !== {1'b0, 4'b0000, 1'b1}) begin
            n_fail++;
            $display("FAIL rstlk_reset: got vld=%b rdy=%b idle=%b expected 0 0000 1",
                     rf_wr_vld, fu_wb_rdy, idle);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        fu_wb_vld = '0;
        rf_wr_rdy = 1'b1;
        repeat (3) step();
        @(negedge clk);
        n_chk++;
        if ({rf_wr_vld, idle} !== 2'b01) begin
            n_fail++;
            $display("FAIL rstlk_idle: got vld=%b idle=%b expected 0 1",
                     rf_wr_vld, idle);
        end
        adv();
        load(0, 8'h60, 3'd0, 16'h0800, 16'h6000, 1'b1);
        load(3, 8'h63, 3'd3, 16'h0803, 16'h6003, 1'b1);
        @(negedge clk);
        n_chk++;
        if (fu_wb_rdy !== 4'b0001) begin
            n_fail++;
            $display("FAIL rstlk_ptr: got rdy=%b expected 0001", fu_wb_rdy);
        end
        adv();
        drain("rstlk");
    endtask

`ifndef WB_ARB_OUT_REG_EN
    task automatic test_protocol_error();
        rf_wr_rdy = 1'b0;
        load(2, 8'h72, 3'd2, 16'h0902, 16'h7002, 1'b0);
        step();
        fu_wb_vld[2] = 1'b0;
        load(1, 8'h71, 3'd1, 16'h0901, 16'h7001, 1'b1);
        rf_wr_rdy = 1'b1;
        @(negedge clk);
        n_chk++;
        if ({fu_wb_rdy, rf_wr_vld} !== {4'b0000, 1'b0}) begin
            n_fail++;
            $display("FAIL perr_cycle: got rdy=%b vld=%b expected 0000 0",
                     fu_wb_rdy, rf_wr_vld);
        end
        adv();
        @(negedge clk);
        n_chk++;
        if (fu_wb_rdy !== 4'b0010) begin
            n_fail++;
            $display("FAIL perr_rearb: got rdy=%b expected 0010",
                     fu_wb_rdy);
        end
        adv();
        drain("perr");
    endtask
`endif

    initial begin
        test_reset();
        test_round_robin();
        test_lock();
        test_single();
        test_back_to_back();
        test_reset_locked();
`ifndef WB_ARB_OUT_REG_EN
        test_protocol_error();
`endif
        repeat (2) step();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
